red_pitaya_asg_out: RTL

Downstream output-conditioning stage for one ASG channel. It sits between the channel generator's 14-bit sample output and the DAC data mux.
- Soft enable: gain ramps up on enable and down on disable, so outputs never step.
- Clamps samples to programmable safe limits, then applies per-cycle slew-rate limiting.
- Reports state, clamp and slew activity to the register bank.

---
 rtl/red_pitaya_asg_out.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_asg_out.sv
// red_pitaya_asg_out: soft-enable gain ramp, clamp and slew limiter for one ASG channel.
// Define ASG_OUT_PEAK_EN to build the dac_o peak max/min detectors.
module red_pitaya_asg_out #(
  parameter int DW = 14,
  parameter int GW = 15
) (
  input  logic                 dac_clk_i,
  input  logic                 dac_rst_i,
  input  logic signed [DW-1:0] dat_i,
  input  logic                 en_i,
  input  logic        [GW-1:0] set_ramp_i,
  input  logic        [DW-2:0] set_slew_i,
  input  logic signed [DW-1:0] set_lim_hi_i,
  input  logic signed [DW-1:0] set_lim_lo_i,
  input  logic                 pk_clr_i,
  output logic signed [DW-1:0] dac_o,
  output logic        [1:0]    state_o,
  output logic                 sat_o,
  output logic                 slew_o,
  output logic                 off_o,
  output logic signed [DW-1:0] pk_max_o,
  output logic signed [DW-1:0] pk_min_o
);

  localparam int PW = DW + GW + 1;
  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_UP  = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  localparam logic [1:0] ST_DN  = 2'd3;
  localparam logic [GW-1:0] G_ONE = GW'(2 ** DW);

  logic [1:0]           r_state;
  logic [GW-1:0]        r_gain;
  logic                 r_off;
  logic signed [PW-1:0] r_prod;
  logic                 r_p_off;
  logic signed [DW-1:0] r_tgt;
  logic                 r_sat;
  logic signed [DW-1:0] r_dac;
  logic                 r_slew;

  logic [1:0]    w_state_nx;
  logic [GW-1:0] w_gain_nx;
  logic [GW:0]   w_up;
  logic [GW:0]   w_dn;

  assign w_up = {1'b0, r_gain} + {1'b0, set_ramp_i};
  assign w_dn = {1'b0, r_gain} - {1'b0, set_ramp_i};

  always_comb begin
    w_state_nx = r_state;
    w_gain_nx  = r_gain;
    case (r_state)
      ST_OFF: begin
        if (en_i) w_state_nx = ST_UP;
      end
      ST_UP: begin
        if (!en_i) begin
          w_state_nx = ST_DN;
        end else if (set_ramp_i == '0 || w_up >= {1'b0, G_ONE}) begin
          w_gain_nx  = G_ONE;
          w_state_nx = ST_RUN;
        end else begin
          w_gain_nx = w_up[GW-1:0];
        end
      end
      ST_RUN: begin
        w_gain_nx = G_ONE;
        if (!en_i) w_state_nx = ST_DN;
      end
      default: begin
        // borrow out of w_dn means the step undershot zero
        if (en_i) begin
          w_state_nx = ST_UP;
        end else if (set_ramp_i == '0 || w_dn[GW] || w_dn == '0) begin
          w_gain_nx  = '0;
          w_state_nx = ST_OFF;
        end else begin
          w_gain_nx = w_dn[GW-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      r_state <= ST_OFF;
      r_gain  <= '0;
      r_off   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gain  <= w_gain_nx;
      r_off   <= (r_state == ST_DN) && (w_state_nx == ST_OFF);
    end
  end

  logic signed [PW-1:0] w_prod;
  assign w_prod = dat_i * $signed({1'b0, r_gain});

  logic signed [DW+1:0] w_t;
  logic signed [DW+1:0] w_hi;
  logic signed [DW+1:0] w_lo;
  logic signed [DW+1:0] w_t1;
  logic signed [DW+1:0] w_t2;

  assign w_t  = r_prod[PW-1:DW];
  assign w_hi = set_lim_hi_i;
  assign w_lo = set_lim_lo_i;
  assign w_t1 = (w_t > w_hi) ? w_hi : w_t;
  assign w_t2 = (w_t1 < w_lo) ? w_lo : w_t1;

  logic signed [DW:0] w_d;
  logic        [DW:0] w_abs;
  logic        [DW:0] w_slw;

  assign w_d   = {r_tgt[DW-1], r_tgt} - {r_dac[DW-1], r_dac};
  assign w_abs = w_d[DW] ? (~w_d + 1'b1) : w_d;
  assign w_slw = {2'b00, set_slew_i};

  // the OFF flag travels with the product so in-flight samples drain out
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      r_prod  <= '0;
      r_p_off <= 1'b1;
      r_tgt   <= '0;
      r_sat   <= 1'b0;
      r_dac   <= '0;
      r_slew  <= 1'b0;
    end else begin
      r_prod  <= w_prod;
      r_p_off <= (r_state == ST_OFF);
      if (r_p_off) begin
        r_tgt <= '0;
        r_sat <= 1'b0;
      end else begin
        r_tgt <= w_t2[DW-1:0];
        r_sat <= (w_t > w_hi) || (w_t1 < w_lo);
      end
      if (set_slew_i == '0 || w_abs <= w_slw) begin
        r_dac  <= r_tgt;
        r_slew <= 1'b0;
      end else begin
        r_dac  <= w_d[DW] ? r_dac - $signed({1'b0, set_slew_i})
                          : r_dac + $signed({1'b0, set_slew_i});
        r_slew <= 1'b1;
      end
    end
  end

  assign dac_o   = r_dac;
  assign state_o = r_state;
  assign sat_o   = r_sat;
  assign slew_o  = r_slew;
  assign off_o   = r_off;

`ifdef ASG_OUT_PEAK_EN
  logic signed [DW-1:0] r_pk_max;
  logic signed [DW-1:0] r_pk_min;
  localparam logic signed [DW-1:0] PK_LO = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] PK_HI = {1'b0, {(DW-1){1'b1}}};

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i || pk_clr_i) begin
      r_pk_max <= PK_LO;
      r_pk_min <= PK_HI;
    end else begin
      if (r_dac > r_pk_max) r_pk_max <= r_dac;
      if (r_dac < r_pk_min) r_pk_min <= r_dac;
    end
  end

  assign pk_max_o = r_pk_max;
  assign pk_min_o = r_pk_min;

  logic w_unused;
  assign w_unused = ^r_prod[DW-1:0];
`else
  assign pk_max_o = '0;
  assign pk_min_o = '0;

  logic w_unused;
  assign w_unused = ^{r_prod[DW-1:0], pk_clr_i};
`endif

endmodule
